fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter.sv | 150 +++++++++++++++
 tb/tb_fb_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_arbiter
// Description : Frame-buffer port arbiter. Display reads and camera writes
//               share one synchronous memory port. Reads win by default,
//               but a bounded starvation counter forces a pending write
//               through after STARVE_MAX consecutive read grants. Read data
//               is returned in order through a latency-matched valid pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter #(
    parameter int AW         = 19,
    parameter int DW         = 24,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    input  logic          I_RD_VALID,
    output logic          O_RD_READY,
    input  logic [AW-1:0] I_RD_ADDR,
    output logic [DW-1:0] O_RD_DATA,
    output logic          O_RD_DVALID,
    input  logic          I_WR_VALID,
    output logic          O_WR_READY,
    input  logic [AW-1:0] I_WR_ADDR,
    input  logic [DW-1:0] I_WR_DATA,
    output logic          O_MEM_CS,
    output logic          O_MEM_WE,
    output logic [AW-1:0] O_MEM_ADDR,
    output logic [DW-1:0] O_MEM_WDATA,
    input  logic [DW-1:0] I_MEM_RDATA
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RD      = 2'd1;
    localparam logic [1:0] c_ST_WR      = 2'd2;
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [3:0]        starve_q;
    logic [3:0]        starve_d;
    logic              w_rd_grant;
    logic              w_wr_grant;
    logic              w_mem_cs;
    logic              w_mem_we;
    logic [AW-1:0]     mem_addr_q;
    logic [DW-1:0]     mem_wdata_q;
    logic [RD_LAT-1:0] rd_vld_q;
    logic [RD_LAT-1:0] rd_vld_d;
    logic [DW-1:0]     rd_data_q;
    logic              rd_dvalid_q;

    // Grant decision: reads first unless the pending write has waited long enough.
    always_comb begin
        w_rd_grant = 1'b0;
        w_wr_grant = 1'b0;
        if (I_RST_N) begin
            if (I_RD_VALID && (!I_WR_VALID || (starve_q < c_STARVE_MAX))) begin
                w_rd_grant = 1'b1;
            end else if (I_WR_VALID) begin
                w_wr_grant = 1'b1;
            end
        end
    end

    // Starvation count: consecutive read grants that overtook a waiting write.
    always_comb begin
        starve_d = 4'd0;
        if (w_rd_grant && I_WR_VALID) begin
            starve_d = (starve_q >= c_STARVE_MAX) ? c_STARVE_MAX : starve_q + 4'd1;
        end
    end

    // FSM state register and starvation counter.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q  <= c_ST_IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // FSM next state follows this cycle's grant.
    always_comb begin
        state_d = c_ST_IDLE;
        if (w_rd_grant) begin
            state_d = c_ST_RD;
        end else if (w_wr_grant) begin
            state_d = c_ST_WR;
        end
    end

    // FSM outputs: the state itself is the registered memory strobe.
    always_comb begin
        w_mem_cs = (state_q != c_ST_IDLE);
        w_mem_we = (state_q == c_ST_WR);
    end

    // Memory address/data: load on accept, otherwise hold the last values.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (w_rd_grant) begin
            mem_addr_q  <= I_RD_ADDR;
        end else if (w_wr_grant) begin
            mem_addr_q  <= I_WR_ADDR;
            mem_wdata_q <= I_WR_DATA;
        end
    end

    // Read-valid pipe input: one slot per cycle, shifting toward the capture stage.
    generate
        if (RD_LAT == 1) begin : g_pipe_single
            assign rd_vld_d = w_rd_grant;
        end else begin : g_pipe_multi
            assign rd_vld_d = {rd_vld_q[RD_LAT-2:0], w_rd_grant};
        end
    endgenerate

    // Read return path: capture memory data when the oldest slot matures.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            rd_vld_q    <= '0;
            rd_data_q   <= '0;
            rd_dvalid_q <= 1'b0;
        end else begin
            rd_vld_q    <= rd_vld_d;
            rd_dvalid_q <= rd_vld_q[RD_LAT-1];
            if (rd_vld_q[RD_LAT-1]) begin
                rd_data_q <= I_MEM_RDATA;
            end
        end
    end

    assign O_RD_READY  = w_rd_grant;
    assign O_WR_READY  = w_wr_grant;
    assign O_MEM_CS    = w_mem_cs;
    assign O_MEM_WE    = w_mem_we;
    assign O_MEM_ADDR  = mem_addr_q;
    assign O_MEM_WDATA = mem_wdata_q;
    assign O_RD_DATA   = rd_data_q;
    assign O_RD_DVALID = rd_dvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_arbiter
// Description : Scoreboard bench for fb_arbiter with a behavioural memory
//               and an arbitration reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;

    localparam int AW         = 19;
    localparam int DW         = 24;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;
    localparam int MEM_WORDS  = 1024;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          I_RD_VALID = 1'b0;
    logic          O_RD_READY;
    logic [AW-1:0] I_RD_ADDR = '0;
    logic [DW-1:0] O_RD_DATA;
    logic          O_RD_DVALID;
    logic          I_WR_VALID = 1'b0;
    logic          O_WR_READY;
    logic [AW-1:0] I_WR_ADDR = '0;
    logic [DW-1:0] I_WR_DATA = '0;
    logic          O_MEM_CS;
    logic          O_MEM_WE;
    logic [AW-1:0] O_MEM_ADDR;
    logic [DW-1:0] O_MEM_WDATA;
    logic [DW-1:0] I_MEM_RDATA;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_cnt = 0;
    logic mem_init = 1'b1;

    // reference model state
    logic [DW-1:0] mdl [0:MEM_WORDS-1];
    int            s_mdl = 0;
    exp_t          rdq[$];
    logic          rd_g, wr_g;
    logic          exp_cs = 1'b0, exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic [DW-1:0] last_rd = '0;

    // behavioural memory
    logic [DW-1:0] phys  [0:MEM_WORDS-1];
    logic [DW-1:0] mpipe [0:3];

    fb_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .I_CLK(clk),
        .I_RST_N(rst_n),
        .I_RD_VALID(I_RD_VALID),
        .O_RD_READY(O_RD_READY),
        .I_RD_ADDR(I_RD_ADDR),
        .O_RD_DATA(O_RD_DATA),
        .O_RD_DVALID(O_RD_DVALID),
        .I_WR_VALID(I_WR_VALID),
        .O_WR_READY(O_WR_READY),
        .I_WR_ADDR(I_WR_ADDR),
        .I_WR_DATA(I_WR_DATA),
        .O_MEM_CS(O_MEM_CS),
        .O_MEM_WE(O_MEM_WE),
        .O_MEM_ADDR(O_MEM_ADDR),
        .O_MEM_WDATA(O_MEM_WDATA),
        .I_MEM_RDATA(I_MEM_RDATA)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: initial content word[a] = a; writes land when the command is seen.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++) phys[i] <= DW'(i);
        end else if (O_MEM_CS && O_MEM_WE) begin
            phys[O_MEM_ADDR[9:0]] <= O_MEM_WDATA;
        end
        mpipe[0] <= phys[O_MEM_ADDR[9:0]];
        for (int i = 1; i < 4; i++) mpipe[i] <= mpipe[i-1];
    end

    generate
        if (RD_LAT == 1) begin : g_mem_comb
            assign I_MEM_RDATA = phys[O_MEM_ADDR[9:0]];
        end else begin : g_mem_reg
            assign I_MEM_RDATA = mpipe[RD_LAT-2];
        end
    endgenerate

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: arbitration rules, expected memory command, expected read data.
    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++) mdl[i] = DW'(i);
        end
        if (!rst_n) begin
            chk("rst_rd_ready", 32'(O_RD_READY), 32'd0);
            chk("rst_wr_ready", 32'(O_WR_READY), 32'd0);
            chk("rst_mem_cs",   32'(O_MEM_CS),   32'd0);
            chk("rst_mem_we",   32'(O_MEM_WE),   32'd0);
            chk("rst_mem_addr", 32'(O_MEM_ADDR), 32'd0);
            chk("rst_mem_wdata",32'(O_MEM_WDATA),32'd0);
            exp_cs = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
            s_mdl = 0;
            rdq.delete();
        end else begin
            chk("mem_cs",    32'(O_MEM_CS),    32'(exp_cs));
            chk("mem_we",    32'(O_MEM_WE),    32'(exp_we));
            chk("mem_addr",  32'(O_MEM_ADDR),  32'(exp_addr));
            chk("mem_wdata", 32'(O_MEM_WDATA), 32'(exp_wdata));
            rd_g = 1'b0;
            wr_g = 1'b0;
            if (I_RD_VALID && I_WR_VALID) begin
                if (s_mdl < STARVE_MAX) rd_g = 1'b1;
                else                    wr_g = 1'b1;
            end else if (I_RD_VALID) begin
                rd_g = 1'b1;
            end else if (I_WR_VALID) begin
                wr_g = 1'b1;
            end
            chk("rd_ready", 32'(O_RD_READY), 32'(rd_g));
            chk("wr_ready", 32'(O_WR_READY), 32'(wr_g));
            s_mdl  = (rd_g && I_WR_VALID) ? s_mdl + 1 : 0;
            exp_cs = rd_g | wr_g;
            exp_we = wr_g;
            if (rd_g) begin
                exp_addr = I_RD_ADDR;
                rdq.push_back('{data: mdl[I_RD_ADDR[9:0]], due: cyc + 1 + RD_LAT});
            end
            if (wr_g) begin
                exp_addr  = I_WR_ADDR;
                exp_wdata = I_WR_DATA;
                mdl[I_WR_ADDR[9:0]] = I_WR_DATA;
                wr_cnt++;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rd_dvalid", 32'(O_RD_DVALID), 32'd0);
            chk("rst_rd_data",   32'(O_RD_DATA),   32'd0);
            last_rd = '0;
        end else if (O_RD_DVALID) begin
            if (rdq.size() == 0) begin
                chk("rd_dvalid_spurious", 32'(O_RD_DVALID), 32'd0);
            end else begin
                exp_t e;
                e = rdq.pop_front();
                chk("rd_data", 32'(O_RD_DATA), 32'(e.data));
                chk("rd_latency_cycle", 32'(cyc), 32'(e.due));
                last_rd = e.data;
            end
        end else begin
            chk("rd_data_hold", 32'(O_RD_DATA), 32'(last_rd));
            if (rdq.size() != 0 && rdq[0].due <= cyc) begin
                chk("rd_dvalid_missing", 32'(O_RD_DVALID), 32'd1);
                void'(rdq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        I_RD_VALID = 1'b0;
        I_WR_VALID = 1'b0;
        repeat (n) step();
    endtask

    task automatic wait_rd_accept();
        bit done = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            done = O_RD_READY;
            step();
        end
        if (!done) chk("rd_accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_wr_accept();
        bit done = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            done = O_WR_READY;
            step();
        end
        if (!done) chk("wr_accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic rd_req(input logic [AW-1:0] a);
        I_RD_VALID = 1'b1;
        I_RD_ADDR  = a;
        wait_rd_accept();
        I_RD_VALID = 1'b0;
    endtask

    task automatic wr_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
        I_WR_VALID = 1'b1;
        I_WR_ADDR  = a;
        I_WR_DATA  = d;
        wait_wr_accept();
        I_WR_VALID = 1'b0;
    endtask

    // Random requesters that hold each request until it is accepted.
    task automatic traffic(input int n, input int rd_pct, input int wr_pct);
        bit ra, wa;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            ra = I_RD_VALID & O_RD_READY;
            wa = I_WR_VALID & O_WR_READY;
            step();
            if (!I_RD_VALID || ra) begin
                I_RD_VALID = (int'($urandom_range(99)) < rd_pct);
                I_RD_ADDR  = AW'($urandom_range(31));
            end
            if (!I_WR_VALID || wa) begin
                I_WR_VALID = (int'($urandom_range(99)) < wr_pct);
                I_WR_ADDR  = AW'($urandom_range(31));
                I_WR_DATA  = DW'($urandom);
            end
        end
    endtask

    initial begin
        int w0;
        repeat (2) step();
        mem_init = 1'b0;
        // requests already pending while reset is held
        I_RD_VALID = 1'b1;
        I_WR_VALID = 1'b1;
        I_RD_ADDR  = '0;
        I_WR_ADDR  = AW'(20'h00300);
        I_WR_DATA  = 24'h777777;
        step();
        I_WR_VALID = 1'b0;
        step();
        rst_n = 1'b1;

        // burst of 640 reads, addr 0..639, first accepted right after release
        for (int a = 0; a < 640; a++) begin
            I_RD_ADDR = AW'(a);
            wait_rd_accept();
        end
        idle(RD_LAT + 4);

        // single write then single read returning 0xA5A5A5
        wr_req(AW'(20'h00010), 24'hA5A5A5);
        idle(1);
        rd_req(AW'(20'h00010));
        idle(RD_LAT + 3);

        // single write at the top of the frame buffer
        wr_req(AW'(20'h4AFFF), 24'h123456);
        idle(RD_LAT + 3);

        // contention: both requesters busy for 20 cycles
        w0 = wr_cnt;
        I_RD_VALID = 1'b1;
        I_WR_VALID = 1'b1;
        traffic(20, 100, 100);
        chk("contention_writes", 32'(wr_cnt - w0), 32'(20 / (STARVE_MAX + 1)));
        idle(RD_LAT + 3);

        // reset right after two accepted reads
        I_RD_VALID = 1'b1;
        I_RD_ADDR  = AW'(100);
        wait_rd_accept();
        I_RD_ADDR  = AW'(101);
        wait_rd_accept();
        rst_n = 1'b0;
        I_RD_VALID = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        idle(8);
        rd_req(AW'(102));
        idle(RD_LAT + 3);

        // write-only stream with idle gaps
        for (int i = 0; i < 6; i++) begin
            wr_req(AW'(20'h00200 + 20'(i * 3)), DW'($urandom));
            idle(2);
        end

        // randomized mixed traffic
        traffic(2000, 60, 55);
        idle(RD_LAT + 6);
        chk("scoreboard_drained", 32'(rdq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
